// File: rtl/adder_bist_pkg.sv
// Shared types and sizing helpers for the adder built-in self-tester.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH = 2;
    localparam int unsigned VEC_W     = 2 * DEF_WIDTH + 1;

    function automatic int unsigned vec_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

    function automatic int unsigned num_vec(input int unsigned width);
        return 32'd1 << (2 * width + 1);
    endfunction

endpackage

// File: rtl/adder_bist_golden.sv
// Combinational reference adder; result is {carry, sum} at full WIDTH+1 precision.
module adder_bist_golden #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH:0]   o_res
);

    assign o_res = (WIDTH+1)'(i_a) + (WIDTH+1)'(i_b) + (WIDTH+1)'(i_cin);

endmodule

// File: rtl/adder_bist.sv
// Exhaustive {a,b,cin} sweep of an external adder with a drive/check pipeline,
// saturating mismatch counter and first-failing-vector capture.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ERR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_carry,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH:0]   first_fail
);

    localparam int unsigned VW = vec_w(WIDTH);
    localparam logic [VW-1:0] VEC_LAST = {VW{1'b1}};

    state_t           r_state;
    logic [VW-1:0]    r_vec;
    logic [VW-1:0]    r_cap_vec;
    logic [WIDTH:0]   r_cap_res;
    logic             r_cap_valid;
    logic [ERR_W-1:0] r_err;
    logic [VW-1:0]    r_first;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic [WIDTH:0]   w_exp;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // Check stage: reference result for the vector captured last cycle
    adder_bist_golden #(.WIDTH(WIDTH)) u_golden (
        .i_a   (r_cap_vec[VW-1 -: WIDTH]),
        .i_b   (r_cap_vec[WIDTH:1]),
        .i_cin (r_cap_vec[0]),
        .o_res (w_exp)
    );

    always_comb begin
        w_mismatch = r_cap_valid && (r_cap_res != w_exp);
        w_err_next = r_err;
        if (w_mismatch && !(&r_err)) begin
            w_err_next = r_err + ERR_W'(1);
        end
    end

    // r_vec is both the sweep counter and the registered drive onto the adder
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_vec       <= '0;
            r_cap_vec   <= '0;
            r_cap_res   <= '0;
            r_cap_valid <= 1'b0;
            r_err       <= '0;
            r_first     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            r_cap_vec   <= r_vec;
            r_cap_res   <= {dut_carry, dut_sum};
            r_cap_valid <= (r_state == ST_RUN);
            r_err       <= w_err_next;
            if (w_mismatch && (r_err == '0)) begin
                r_first <= r_cap_vec;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_vec       <= '0;
                        r_err       <= '0;
                        r_first     <= '0;
                        r_cap_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_vec == VEC_LAST) begin
                        r_state <= ST_FLUSH;
                        r_vec   <= '0;
                    end else begin
                        r_vec <= r_vec + VW'(1);
                    end
                end
                ST_FLUSH: begin
                    // Last compare retires this edge, so pass uses the updated count
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_err_next == '0);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dut_a      = r_vec[VW-1 -: WIDTH];
    assign dut_b      = r_vec[WIDTH:1];
    assign dut_cin    = r_vec[0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign first_fail = r_first;

endmodule

// File: tb/tb_adder_bist.sv
// Scoreboard bench for adder_bist: a fault-injectable adder model feeds two
// instances (ERR_W=6 and ERR_W=4) swept in lockstep.
module tb_adder_bist;
    import adder_bist_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned VW = 2 * W + 1;
    localparam int          NV = int'(num_vec(W));

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;

    logic [W-1:0]  a6, b6, sum6, a4, b4, sum4;
    logic          cin6, carry6, cin4, carry4;
    logic          busy6, done6, pass6, busy4, done4, pass4;
    logic [5:0]    err6;
    logic [3:0]    err4;
    logic [VW-1:0] ff6, ff4;

    int          fault_mode = 0;
    logic [31:0] bad_mask   = '0;
    int          cyc        = 0;
    int          n_tests    = 0;
    int          n_fail     = 0;
    bit          aborted    = 1'b0;
    int          bidx       = 0;
    logic        prev_busy  = 1'b0;
    logic        prev_done  = 1'b0;

    typedef struct {
        int err6;
        int err4;
        int ff;
        int pass;
        int start_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_bist #(.WIDTH(W), .ERR_W(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a6), .dut_b(b6), .dut_cin(cin6),
        .dut_sum(sum6), .dut_carry(carry6),
        .busy(busy6), .done(done6), .pass(pass6),
        .err_count(err6), .first_fail(ff6)
    );

    adder_bist #(.WIDTH(W), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start),
        .dut_a(a4), .dut_b(b4), .dut_cin(cin4),
        .dut_sum(sum4), .dut_carry(carry4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .first_fail(ff4)
    );

    // Adder under test: 1 = carry stuck-at-0, 2 = sum[0] inverted, 3 = sum[0] inverted on masked vectors
    function automatic logic [W:0] adder_model(input int unsigned va, input int unsigned vb,
                                               input int unsigned vc, input int mode,
                                               input logic [31:0] mask);
        int unsigned s;
        int unsigned idx;
        s   = va + vb + vc;
        idx = va * 8 + vb * 2 + vc;
        case (mode)
            1: s = s % (32'd1 << W);
            2: s = s ^ 32'd1;
            3: if (mask[idx]) s = s ^ 32'd1;
            default: ;
        endcase
        return (W+1)'(s);
    endfunction

    always_comb {carry6, sum6} = adder_model(32'(a6), 32'(b6), 32'(cin6), fault_mode, bad_mask);
    always_comb {carry4, sum4} = adder_model(32'(a4), 32'(b4), 32'(cin4), fault_mode, bad_mask);

    // Reference: walk all vectors in {a,b,cin} order and count wrong adder answers
    function automatic exp_t build_exp(input int mode, input logic [31:0] mask);
        exp_t e;
        int cnt;
        int first;
        int unsigned va, vb, vc;
        cnt   = 0;
        first = 0;
        for (int v = 0; v < NV; v++) begin
            va = 32'(v / 8);
            vb = 32'((v / 2) % 4);
            vc = 32'(v % 2);
            if (adder_model(va, vb, vc, mode, mask) != (W+1)'(va + vb + vc)) begin
                if (cnt == 0) first = v;
                cnt++;
            end
        end
        e.err6      = (cnt > 63) ? 63 : cnt;
        e.err4      = (cnt > 15) ? 15 : cnt;
        e.ff        = first;
        e.pass      = (cnt == 0) ? 1 : 0;
        e.start_cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: drive sequence, busy length, and sweep results on done rising
    always @(negedge clk) begin
        exp_t e;
        if (busy6) begin
            if (!prev_busy) bidx = 0;
            if (bidx < NV) check("vec_seq", int'({a6, b6, cin6}), bidx);
            else           check("flush_vec", int'({a6, b6, cin6}), 0);
            bidx++;
        end else if (prev_busy && !aborted) begin
            check("busy_len", bidx, NV + 1);
        end
        if (done6 && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("latency", cyc - e.start_cyc, NV + 1);
                check("err_count", int'(err6), e.err6);
                check("err_count_w4", int'(err4), e.err4);
                check("pass", int'(pass6), e.pass);
                if (e.err6 != 0) check("first_fail", int'(ff6), e.ff);
                check("idle_drive", int'({a6, b6, cin6}), 0);
                check("busy_at_done", int'(busy6), 0);
            end
        end
        prev_busy = busy6;
        prev_done = done6;
    end

    task automatic run_sweep(input int mode, input logic [31:0] mask, input int hold);
        exp_t e;
        bit   was_done;
        @(negedge clk);
        fault_mode = mode;
        bad_mask   = mask;
        e          = build_exp(mode, mask);
        was_done   = done6;
        start      = 1'b1;
        @(posedge clk);
        #1;
        e.start_cyc = cyc;
        sb.push_back(e);
        if (was_done) check("done_drop", int'(done6), 0);
        check("busy_rise", int'(busy6), 1);
        for (int i = 1; i < hold; i++) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < NV + 20 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            check("sweep_timeout", 1, 0);
            sb.delete();
        end
    endtask

    task automatic reset_mid_sweep();
        @(negedge clk);
        fault_mode = 2;
        start      = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(build_exp(2, '0));
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        aborted = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("rst_err", int'(err6), 0);
        check("rst_ff", int'(ff6), 0);
        check("rst_busy", int'(busy6), 0);
        check("rst_done", int'(done6), 0);
        check("rst_pass", int'(pass6), 0);
        check("rst_drive", int'({a6, b6, cin6}), 0);
        repeat (4) @(negedge clk);
        check("post_rst_err", int'(err6), 0);
        check("post_rst_busy", int'(busy6), 0);
        check("post_rst_done", int'(done6), 0);
        aborted = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_err", int'(err6), 0);
        check("init_ff", int'(ff6), 0);
        check("init_busy", int'(busy6), 0);
        check("init_done", int'(done6), 0);
        check("init_pass", int'(pass6), 0);
        check("init_drive", int'({a6, b6, cin6}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_sweep(0, '0, 1);
        run_sweep(1, '0, 1);
        run_sweep(2, '0, 1);
        run_sweep(0, '0, 20);
        reset_mid_sweep();
        run_sweep(2, '0, 1);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_sweep(3, 32'($urandom()), int'($urandom_range(1, 25)));
        end
        run_sweep(0, '0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
